// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-memory loader of the 4-bit nibble processor.
// Holds the program address width, memory depth, loader FSM encoding and the
// split of a program byte into its instruction and operand nibbles.
package prog_loader_pkg;

  localparam int ADDR_W    = 12;
  localparam int MEM_DEPTH = 2 ** ADDR_W;

  // Loader FSM encoding; values are fixed so they can be probed on a bus.
  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  // One program byte: instr in [7:4], oprnd in [3:0].
  typedef struct packed {
    logic [3:0] instr;
    logic [3:0] oprnd;
  } prog_byte_t;

endpackage

// File: rtl/prog_loader_mem.sv
// Program memory: MEM_DEPTH x 8, one synchronous write port, one combinational read port.
// Latency: writes land on the rising edge; reads are zero-latency and return pre-edge data.
// Backpressure: none, the write port accepts every cycle. Contents are never reset.
// Ports: clock_i; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o read port.
module prog_mem
  import prog_loader_pkg::*;
(
  input  logic              clock_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  prog_byte_t mem_q [MEM_DEPTH];

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= prog_byte_t'(wdata_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams bytes into program memory from address 0 and holds the CPU in reset meanwhile.
// Latency: byte_ready 1 cycle after load_start; N bytes -> RUN and done N+1 cycles after the last-byte edge minus N.
// Backpressure: byte_ready high only in LOAD; source may stall byte_valid indefinitely, no timeout.
// Ports: clock_i/reset_i (async, active high); load_start_i/load_len_i start a session;
//        byte_valid_i/byte_data_i/byte_ready_o byte stream; pc_i -> program_byte_o fetch path;
//        cpu_reset_o, busy_o, done_o, load_addr_o, checksum_o status.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [7:0]        program_byte_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] load_addr_o,
  output logic [7:0]        checksum_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [7:0]        checksum_q, checksum_d;
  logic              done_q, done_d;

  logic start;
  logic xfer;

  // load_start only counts while idle or running; it is ignored mid-load.
  assign start = load_start_i && ((state_q == ST_HALT) || (state_q == ST_RUN));
  assign xfer  = byte_valid_i && byte_ready_o;

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALT:    if (start) state_d = ST_LOAD;
      // remain_q counts bytes still owed after this one, so 0 marks the last byte.
      ST_LOAD:    if (xfer && (remain_q == '0)) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN:     if (start) state_d = ST_LOAD;
      default:    state_d = ST_HALT;
    endcase
  end

  // Outputs decoded straight from the state register, so cpu_reset only moves on edges.
  always_comb begin
    cpu_reset_o  = (state_q != ST_RUN);
    byte_ready_o = (state_q == ST_LOAD);
    busy_o       = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
  end

  // Datapath: address, remaining count and checksum.
  always_comb begin
    load_addr_d = load_addr_q;
    remain_d    = remain_q;
    checksum_d  = checksum_q;
    if (start) begin
      load_addr_d = '0;
      remain_d    = load_len_i;
      checksum_d  = '0;
    end else if (xfer) begin
      // Wraps to 0 only after the 4096th byte of a full-length load.
      load_addr_d = load_addr_q + ADDR_W'(1);
      remain_d    = remain_q - ADDR_W'(1);
      checksum_d  = checksum_q + byte_data_i;
    end
  end

  // done pulses for the single cycle following RELEASE, i.e. on entry to RUN.
  assign done_d = (state_q == ST_RELEASE);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      load_addr_q <= '0;
      remain_q    <= '0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      load_addr_q <= load_addr_d;
      remain_q    <= remain_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
    end
  end

  assign done_o      = done_q;
  assign load_addr_o = load_addr_q;
  assign checksum_o  = checksum_q;

  prog_mem u_mem (
    .clock_i (clock_i),
    .we_i    (xfer),
    .waddr_i (load_addr_q),
    .wdata_i (byte_data_i),
    .raddr_i (pc_i),
    .rdata_o (program_byte_o)
  );

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader for the 4-bit nibble processor. Accepts a stream of 8-bit program bytes over a valid/ready handshake and writes them from address 0 upward into a 4096x8 program memory. The processor's fetch path reads this memory combinationally by `pc`. The loader holds the processor in reset while a load is in progress and releases it once the last byte is written, so it replaces the fixed program ROM.

## Interface
- `ADDR_W`, 12: program address width; must match the processor `pc` width.
- `MEM_DEPTH`, 4096: number of program bytes, equal to 2**ADDR_W.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  starts a load session. Sampled only in HALT or RUN.
- `load_len`  in  ADDR_W  byte count minus one (0 means 1 byte, 4095 means 4096 bytes). Latched with `load_start`.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  program byte, {instr[7:4], oprnd[3:0]}.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `pc`  in  ADDR_W  processor program counter.
- `program_byte`  out  8  mem[pc]; combinational read.
- `cpu_reset`  out  1  drive to the processor's `reset`; high except in RUN.
- `busy`  out  1  high in LOAD and RELEASE.
- `done`  out  1  one-cycle pulse on entry to RUN.
- `load_addr`  out  ADDR_W  address the next accepted byte is written to.
- `checksum`  out  8  mod-256 sum of bytes accepted in the current or last session.

## Operation
- FSM states: HALT, LOAD, RELEASE, RUN. Reset state is HALT.
- **HALT**
  - `cpu_reset`=1, `byte_ready`=0.
  - `load_start`=1 -> LOAD.
- **Load start.** On the `load_start` edge (from HALT or RUN):
  - `load_addr` <- 0
  - remaining <- `load_len`
  - `checksum` <- 0
  - state -> LOAD
- **LOAD**
  - `byte_ready`=1, `cpu_reset`=1.
  - Transfer occurs when `byte_valid && byte_ready` at a rising edge. On transfer:
    - mem[`load_addr`] <- `byte_data`
    - `load_addr` +1
    - `checksum` + `byte_data` (wraps mod 256)
    - remaining -1
  - Transfer with remaining==0 is the last byte -> RELEASE.
  - `load_start` is ignored in LOAD.
- **RELEASE**
  - Lasts exactly one cycle. `cpu_reset`=1, `byte_ready`=0.
  - Always -> RUN.
- **RUN**
  - `cpu_reset`=0, `byte_ready`=0.
  - `load_start`=1 -> LOAD, which re-asserts `cpu_reset` and aborts the running program.
- **Memory**
  - Memory contents are not cleared by reset.
  - Bytes beyond the loaded length keep their prior contents.
- **Address wrap.** `load_addr` is ADDR_W bits and wraps 4095 -> 0. This is reachable only in a 4096-byte load, on the final increment, so `load_addr` reads 0 after a full load.
- **Read/write collision.** Same-address read during a write returns the pre-edge contents. The new byte is visible on `program_byte` the cycle after the write.
- **Reset mid-load.** Asynchronous `reset` at any time forces HALT immediately. Partially written memory is kept and the session is abandoned.

## Timing
- Reset values:
  - state=HALT, `cpu_reset`=1, `byte_ready`=0, `busy`=0, `done`=0
  - `load_addr`=0, `checksum`=0
- All outputs except `program_byte` are registered or decoded directly from state.
- `program_byte` is combinational from `pc` and memory, with zero latency.
- `load_start` at edge t: `byte_ready`=1 and `busy`=1 from t+1.
- Throughput: one byte per cycle when `byte_valid` is held high. A load of N bytes started at edge t, with no stalls, has:
  - last write at edge t+N
  - RELEASE during cycle t+N
  - RUN, `done`=1 and `cpu_reset`=0 from edge t+N+1
- `done` is high for exactly one cycle.
- The source may deassert `byte_valid` at any time; there is no timeout.
- `cpu_reset` transitions only on rising edges (glitch-free).

## Structure
- Shared package holds:
  - state encoding localparams (HALT=0, LOAD=1, RELEASE=2, RUN=3)
  - `ADDR_W`
  - the byte-field split: instr = [7:4], oprnd = [3:0]
- Sub-module `prog_mem`: MEM_DEPTH x 8, synchronous write port (we, waddr, wdata), asynchronous read port (raddr -> rdata).
- Top level holds the FSM, counters and checksum.

## Test plan
- **Reset defaults.** Reset, then idle 5 cycles -> `cpu_reset`=1, `byte_ready`=0, `load_addr`=0, `checksum`=0.
- **Short load.** `load_len`=3, bytes 0x1A,0x2B,0x3C,0x4D back-to-back:
  - `done` pulses 5 cycles after `load_start`
  - `checksum`=0xCE
  - `pc`=0..3 reads the 4 bytes
  - `cpu_reset`=0 thereafter
- **Stalls.** Same load with `byte_valid` low on alternate cycles -> identical memory and checksum, RUN reached 4 cycles later.
- **Full wrap.** `load_len`=4095, 4096 bytes of value addr[7:0] ->
  - `load_addr`=0 at the end
  - `checksum`=0x00 (16 x sum 0..255)
  - mem[4095]=0xFF
- **Reload from RUN.** `load_start` in RUN -> `cpu_reset`=1 on the next edge. `load_start` pulsed again during LOAD is ignored (`load_addr` keeps counting).
- **Reset mid-load.** Assert `reset` after 2 of 4 bytes -> HALT immediately. mem[0..1] hold the new bytes and mem[2..3] the old ones.
